// File: rtl/apb_master.sv
// APB3 initiator: one valid/ready command becomes one APB3 transfer and one response.
// Optional watchdog against a hung slave is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_slverr,
  output logic        rsp_timeout,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic        PREADY,
  input  logic [31:0] PRDATA,
  input  logic        PSLVERR,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a beat transfers on a PCLK edge where valid and ready are both
  // high; valid never waits on ready, and response fields hold while rsp_valid=1.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("apb_master: TIMEOUT_CYCLES must be at least 2");
  end

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        slverr_q, slverr_d;
  logic        wd_expire;
  logic        timeout_set;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          timeout_q, timeout_d;

  // Counts consecutive stalled ACCESS cycles; cleared while in SETUP so it is
  // zero on the first ACCESS cycle.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == ST_SETUP) begin
      wd_cnt_d = '0;
    end else if (state_q == ST_ACCESS && !PREADY) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  assign wd_expire = (state_q == ST_ACCESS) && !PREADY &&
                     (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    timeout_d = timeout_q;
    if (state_q == ST_IDLE && cmd_valid) begin
      timeout_d = 1'b0;
    end else if (timeout_set) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign rsp_timeout = timeout_q;
`else
  assign wd_expire   = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    slverr_d    = slverr_q;
    timeout_set = 1'b0;
    cmd_ready   = 1'b0;
    PSEL        = 1'b0;
    PENABLE     = 1'b0;
    rsp_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d   = cmd_addr;
          write_d  = cmd_write;
          wdata_d  = cmd_write ? cmd_wdata : 32'd0;
          rdata_d  = 32'd0;
          slverr_d = 1'b0;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        PSEL    = 1'b1;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        // PREADY wins over a watchdog expiry in the same cycle.
        if (PREADY) begin
          slverr_d = PSLVERR;
          rdata_d  = write_q ? 32'd0 : PRDATA;
          state_d  = ST_RESP;
        end else if (wd_expire) begin
          slverr_d    = 1'b1;
          rdata_d     = 32'd0;
          timeout_set = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= ST_IDLE;
      addr_q   <= 32'd0;
      write_q  <= 1'b0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      slverr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
    end
  end

  assign PADDR       = addr_q;
  assign PWRITE      = write_q;
  assign PWDATA      = wdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_slverr  = slverr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: write, error, wait states, backpressure,
// watchdog (either build) and synchronous reset in the middle of a transfer.
module tb_apb_master;

  localparam int TO = 8;

  logic        PCLK;
  logic        PRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;
  logic [1:0]  dbg_state;

  apb_master #(.TIMEOUT_CYCLES(TO)) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_timeout (rsp_timeout),
    .PADDR       (PADDR),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PREADY      (PREADY),
    .PRDATA      (PRDATA),
    .PSLVERR     (PSLVERR),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  int          checks = 0;
  int          errors = 0;
  int          slv_wait;
  int          acc_cnt;
  logic [31:0] slv_rdata;
  logic        slv_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Slave model: stalls slv_wait ACCESS cycles, then completes. Outside
  // ACCESS it drives deliberately misleading values on PREADY/PRDATA/PSLVERR.
  task automatic slave_update();
    if (PSEL && PENABLE) begin
      PREADY  = (acc_cnt == slv_wait);
      PRDATA  = slv_rdata;
      PSLVERR = (acc_cnt == slv_wait) ? slv_err : 1'b1;
      acc_cnt++;
    end else begin
      PREADY  = 1'b1;
      PRDATA  = 32'hBAD0_BAD0;
      PSLVERR = 1'b1;
      acc_cnt = 0;
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
    slave_update();
  endtask

  // Issues one command from IDLE and runs until rsp_valid or the budget ends.
  // lat counts samples after the accept edge (1 = SETUP).
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waitn, input int budget, output int lat);
    logic [31:0] exp_pwdata;
    bit got;
    exp_pwdata = wr ? wdata : 32'd0;
    slv_wait  = waitn;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    cmd_addr  = ~addr;
    cmd_wdata = 32'h5555_AAAA;
    lat = 1;
    chk("setup_psel", 32'(PSEL), 32'd1);
    chk("setup_penable", 32'(PENABLE), 32'd0);
    chk("setup_state", 32'(dbg_state), 32'd1);
    got = 1'b0;
    while (lat < budget && !got) begin
      chk("xfer_psel", 32'(PSEL), 32'd1);
      chk("xfer_paddr", PADDR, addr);
      chk("xfer_pwrite", 32'(PWRITE), 32'(wr));
      chk("xfer_pwdata", PWDATA, exp_pwdata);
      chk("xfer_cmd_ready", 32'(cmd_ready), 32'd0);
      step();
      lat++;
      if (rsp_valid) got = 1'b1;
    end
    chk("rsp_valid_within_budget", 32'(rsp_valid), 32'd1);
    chk("resp_psel", 32'(PSEL), 32'd0);
    chk("resp_penable", 32'(PENABLE), 32'd0);
  endtask

  int lat;
  int access_cnt;

  initial begin
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'd0;
    cmd_wdata = 32'd0;
    rsp_ready = 1'b0;
    slv_wait  = 0;
    acc_cnt   = 0;
    slv_rdata = 32'd0;
    slv_err   = 1'b0;
    PREADY    = 1'b0;
    PRDATA    = 32'd0;
    PSLVERR   = 1'b0;
    step();
    step();
    PRESET = 1'b0;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_slverr", 32'(rsp_slverr), 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    step();

    // Write, no wait state; PRDATA is non-zero to prove writes return 0.
    slv_err   = 1'b0;
    slv_rdata = 32'hFFFF_FFFF;
    rsp_ready = 1'b1;
    run_txn(1'b1, 32'h05, 32'h1234, 0, 20, lat);
    chk("wr_latency", 32'(lat), 32'd3);
    chk("wr_slverr", 32'(rsp_slverr), 32'd0);
    chk("wr_rdata", rsp_rdata, 32'd0);
    chk("wr_timeout", 32'(rsp_timeout), 32'd0);
    step();
    chk("wr_resp_one_cycle", 32'(rsp_valid), 32'd0);
    chk("wr_back_idle", 32'(cmd_ready), 32'd1);

    // Write error.
    slv_err = 1'b1;
    run_txn(1'b1, 32'h21, 32'h0000_CAFE, 0, 20, lat);
    chk("err_latency", 32'(lat), 32'd3);
    chk("err_slverr", 32'(rsp_slverr), 32'd1);
    chk("err_timeout", 32'(rsp_timeout), 32'd0);
    step();

    // Read with 6 wait states; cmd_wdata garbage must not reach PWDATA.
    slv_err   = 1'b0;
    slv_rdata = 32'h0000_ABCD;
    run_txn(1'b0, 32'h03, 32'hDEAD_BEEF, 6, 40, lat);
    chk("rd6_latency", 32'(lat), 32'd9);
    chk("rd6_rdata", rsp_rdata, 32'h0000_ABCD);
    chk("rd6_slverr", 32'(rsp_slverr), 32'd0);
    step();
    chk("rd6_back_idle", 32'(dbg_state), 32'd0);

    // Backpressure with a second command pending.
    rsp_ready = 1'b0;
    slv_rdata = 32'h1111_2222;
    run_txn(1'b0, 32'h40, 32'h0, 1, 20, lat);
    chk("bp_latency", 32'(lat), 32'd4);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h44;
    cmd_wdata = 32'h77;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h1111_2222);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_psel", 32'(PSEL), 32'd0);
      chk("bp_state", 32'(dbg_state), 32'd3);
      step();
    end
    rsp_ready = 1'b1;
    chk("bp_hold_rsp_valid", 32'(rsp_valid), 32'd1);
    step();
    chk("bp_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp_hs_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("bp_hs_psel", 32'(PSEL), 32'd0);
    slv_wait = 0;
    step();
    cmd_valid = 1'b0;
    chk("bp2_setup_psel", 32'(PSEL), 32'd1);
    chk("bp2_setup_penable", 32'(PENABLE), 32'd0);
    chk("bp2_paddr", PADDR, 32'h44);
    chk("bp2_pwrite", 32'(PWRITE), 32'd1);
    chk("bp2_pwdata", PWDATA, 32'h77);
    step();
    chk("bp2_access", 32'(PENABLE), 32'd1);
    step();
    chk("bp2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp2_rsp_rdata", rsp_rdata, 32'd0);
    chk("bp2_rsp_slverr", 32'(rsp_slverr), 32'd0);
    step();

    // Watchdog.
    slv_rdata = 32'h9999_9999;
`ifdef APB_MASTER_TIMEOUT_EN
    run_txn(1'b0, 32'h10, 32'h0, 1000000, 40, lat);
    chk("to_latency", 32'(lat), 32'(TO + 2));
    chk("to_timeout", 32'(rsp_timeout), 32'd1);
    chk("to_slverr", 32'(rsp_slverr), 32'd1);
    chk("to_rdata", rsp_rdata, 32'd0);
    step();
    chk("to_back_idle", 32'(cmd_ready), 32'd1);
`else
    slv_wait  = 1000000;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h10;
    step();
    cmd_valid  = 1'b0;
    access_cnt = 0;
    for (int i = 0; i < 110; i++) begin
      step();
      if (PSEL && PENABLE && !rsp_valid) access_cnt++;
    end
    chk("nowd_access_cycles", 32'(access_cnt), 32'd110);
    chk("nowd_rsp_timeout", 32'(rsp_timeout), 32'd0);
    PRESET = 1'b1;
    step();
    PRESET = 1'b0;
    chk("nowd_recover_idle", 32'(dbg_state), 32'd0);
`endif

    // Reset in the middle of a stalled read.
    slv_wait  = 1000000;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h30;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("mid_in_access", 32'(PENABLE), 32'd1);
    PRESET = 1'b1;
    step();
    PRESET = 1'b0;
    chk("mid_psel", 32'(PSEL), 32'd0);
    chk("mid_penable", 32'(PENABLE), 32'd0);
    chk("mid_paddr", PADDR, 32'd0);
    chk("mid_pwrite", 32'(PWRITE), 32'd0);
    chk("mid_pwdata", PWDATA, 32'd0);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rsp_rdata", rsp_rdata, 32'd0);
    chk("mid_rsp_slverr", 32'(rsp_slverr), 32'd0);
    chk("mid_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("mid_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_state", 32'(dbg_state), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
    end
    slv_rdata = 32'h0BAD_F00D;
    run_txn(1'b0, 32'h34, 32'h0, 2, 20, lat);
    chk("post_rst_latency", 32'(lat), 32'd5);
    chk("post_rst_rdata", rsp_rdata, 32'h0BAD_F00D);
    chk("post_rst_slverr", 32'(rsp_slverr), 32'd0);
    step();
    chk("post_rst_idle", 32'(cmd_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

APB3 initiator that turns a simple valid/ready command stream into single APB3 transfers and returns one response per command. It sits on the host side of the FIR peripheral's APB3 slave, driving PADDR/PSEL/PENABLE/PWRITE/PWDATA and sampling PREADY/PRDATA/PSLVERR. It is used as the bus driver in system-level benches and by on-chip control logic. It handles slave wait states, including the slave's multi-cycle read latency, and has an optional watchdog against a hung slave.

## Interface
- TIMEOUT_CYCLES, 64: maximum number of ACCESS cycles before a transfer is aborted. Used only when the watchdog is compiled in. Must be ≥2.
- PCLK  in  1  clock
- PRESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  transfer address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high together with rsp_valid
- rsp_rdata  out  32  read data; 0 for writes and aborts
- rsp_slverr  out  1  PSLVERR sampled at completion, or 1 on timeout
- rsp_timeout  out  1  transfer aborted by the watchdog
- PADDR  out  32  APB address
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PREADY  in  1  slave ready
- PRDATA  in  32  slave read data
- PSLVERR  in  1  slave error

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS and RESP. Reset enters IDLE.
- IDLE:
  - cmd_ready=1.
  - When cmd_valid=1 at an edge, register the address, direction and write data, then go to SETUP.
  - PWDATA is set to cmd_wdata for writes and to 0 for reads.
- SETUP: PSEL=1, PENABLE=0. Go to ACCESS unconditionally.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PADDR, PWRITE and PWDATA stay stable for the whole transfer.
  - On an edge with PREADY=1, capture PSLVERR. For reads, also capture PRDATA (rsp_rdata=0 for writes). Then go to RESP.
- RESP:
  - PSEL=0, PENABLE=0, rsp_valid=1.
  - Response outputs are held until rsp_ready=1 at an edge, then go to IDLE.
- Exactly one outstanding transfer; there are no back-to-back transfers. cmd_ready=0 in every state except IDLE.
- PREADY, PRDATA and PSLVERR are ignored outside ACCESS.
- The watchdog counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
- Reset values: every output is 0 except cmd_ready, which is 1 (state IDLE).

## Timing
- Command accepted at edge E0. SETUP runs in cycle E0..E1 and ACCESS starts at E1.
- With PREADY=1 in the first ACCESS cycle, rsp_valid rises after E2. Command-to-response latency is 3 cycles; add one cycle per wait state.
- The next command can be accepted in the cycle after the rsp handshake. Minimum period is 4 cycles per transfer.
- PREADY=1 in the same cycle the watchdog reaches its limit counts as a normal completion; PREADY has priority.
- If rsp_ready is already high when RESP is entered, RESP lasts exactly 1 cycle.
- Reset mid-transfer: at the first edge with PRESET=1, PSEL and PENABLE drop, state returns to IDLE and any pending response is discarded. There is no partial response.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - When TIMEOUT_CYCLES consecutive ACCESS cycles pass with PREADY=0, the transfer aborts.
  - PSEL and PENABLE drop, and the FSM enters RESP with rsp_timeout=1, rsp_slverr=1 and rsp_rdata=0.
- APB_MASTER_TIMEOUT_EN undefined:
  - ACCESS waits indefinitely.
  - rsp_timeout is tied to 0 and no counter is instantiated.

## Test plan
- Write, no wait state: cmd addr=0x05, wdata=0x1234, write=1, slave PREADY=1 in the first ACCESS cycle -> PWDATA=0x1234 through SETUP and ACCESS; rsp_valid 3 cycles after accept with rsp_slverr=0 and rsp_rdata=0.
- Write error: addr=0x21, slave returns PREADY=1 and PSLVERR=1 -> rsp_slverr=1, rsp_timeout=0.
- Read with 6 wait states: addr=0x03, slave raises PREADY after 6 ACCESS cycles with PRDATA=0x0000ABCD -> PADDR and PSEL stable throughout; rsp_rdata=0x0000ABCD; latency 9 cycles.
- Backpressure: rsp_ready=0 for 5 cycles with a second cmd_valid pending -> rsp is held stable, cmd_ready=0, PSEL=0; second command accepted the cycle after the handshake.
- Timeout (macro defined, TIMEOUT_CYCLES=8): PREADY held at 0 -> exactly 8 ACCESS cycles, then rsp_timeout=1, rsp_slverr=1, rsp_rdata=0. With the macro undefined, PSEL remains 1 for more than 100 cycles.
- Reset mid-ACCESS: PRESET=1 for 1 cycle during a read wait -> all outputs 0 and cmd_ready=1 after the edge, no rsp_valid; a new read then completes normally.
